// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: FIFO controller over a 1-cycle-latency external SRAM,
// with a 2-entry output buffer for a full-rate valid/ready output.
// Ports:
//   clk, rst                  clock, sync active-high reset
//   in_valid/in_ready/in_data upstream push handshake
//   out_valid/out_ready/out_data downstream pop handshake
//   addr_w, addr_r, write_en, read_en, sram_wdata, sram_rdata  SRAM side
//   level                     total entries held (SRAM + in flight + obuf)
module sram_fifo_ctrl #(
  parameter int SRAM_DEPTH_BIT = 6,
  parameter int SRAM_DEPTH     = 2**SRAM_DEPTH_BIT,
  parameter int SRAM_WIDTH     = 28
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SRAM_WIDTH-1:0]     in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SRAM_WIDTH-1:0]     out_data,
  output logic [SRAM_DEPTH_BIT-1:0] addr_w,
  output logic [SRAM_DEPTH_BIT-1:0] addr_r,
  output logic                      write_en,
  output logic                      read_en,
  output logic [SRAM_WIDTH-1:0]     sram_wdata,
  input  logic [SRAM_WIDTH-1:0]     sram_rdata,
  output logic [SRAM_DEPTH_BIT+1:0] level
);

  localparam int AW = SRAM_DEPTH_BIT;
  localparam int CW = SRAM_DEPTH_BIT + 1;
  localparam int LW = SRAM_DEPTH_BIT + 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(SRAM_DEPTH);

  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [CW-1:0]         r_scount;
  logic                  r_infl;
  logic [1:0]            r_ocnt;
  logic [SRAM_WIDTH-1:0] r_obuf0;
  logic [SRAM_WIDTH-1:0] r_obuf1;

  logic       w_push;
  logic       w_pop;
  logic       w_read;
  logic [2:0] w_occ;
  logic [2:0] w_lim;

  assign in_ready  = (r_scount < DEPTH_C) & ~rst;
  assign out_valid = (r_ocnt != 2'd0) & ~rst;
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  // Issue a read only if the word will have an obuf slot when it lands.
  assign w_occ  = {1'b0, r_ocnt} + {2'b00, r_infl};
  assign w_lim  = 3'd2 + {2'b00, w_pop};
  assign w_read = ~rst & (r_scount != '0) & (w_occ < w_lim);

  assign write_en   = w_push;
  assign read_en    = w_read;
  assign addr_w     = rst ? '0 : r_wptr;
  assign addr_r     = rst ? '0 : r_rptr;
  assign sram_wdata = rst ? '0 : in_data;
  assign out_data   = rst ? '0 : r_obuf0;
  assign level      = rst ? '0 :
                      LW'(r_scount) + LW'(r_infl) + LW'(r_ocnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_scount <= '0;
      r_infl   <= 1'b0;
      r_ocnt   <= 2'd0;
      r_obuf0  <= '0;
      r_obuf1  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_read) r_rptr <= r_rptr + AW'(1);
      unique case ({w_push, w_read})
        2'b10:   r_scount <= r_scount + CW'(1);
        2'b01:   r_scount <= r_scount - CW'(1);
        default: r_scount <= r_scount;
      endcase
      r_infl <= w_read;
      // obuf0 is always the oldest entry; pop shifts obuf1 down.
      unique case ({r_infl, w_pop})
        2'b10: begin
          if (r_ocnt == 2'd0) r_obuf0 <= sram_rdata;
          else                r_obuf1 <= sram_rdata;
          r_ocnt <= r_ocnt + 2'd1;
        end
        2'b11: begin
          if (r_ocnt == 2'd1) begin
            r_obuf0 <= sram_rdata;
          end else begin
            r_obuf0 <= r_obuf1;
            r_obuf1 <= sram_rdata;
          end
        end
        2'b01: begin
          r_obuf0 <= r_obuf1;
          r_ocnt  <= r_ocnt - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sram_fifo_ctrl.md
SRAM_FIFO_CTRL -- requirements
Module: sram_fifo_ctrl

Interface
REQ-001 The block SHALL have parameter SRAM_DEPTH_BIT, default 6, the SRAM address width.
REQ-002 The block SHALL have parameter SRAM_DEPTH, default 2**SRAM_DEPTH_BIT, the SRAM entry count.
REQ-003 The block SHALL have parameter SRAM_WIDTH, default 28, the data width.
REQ-004 The block SHALL have port clk  in  1  as its single clock; all logic is on the rising edge.
REQ-005 The block SHALL have port rst  in  1  as the reset; reset is synchronous and active-high.
REQ-006 The block SHALL have port in_valid  in  1  as the upstream write request.
REQ-007 The block SHALL have port in_ready  out  1  as the upstream accept indication.
REQ-008 The block SHALL have port in_data  in  SRAM_WIDTH  as the upstream payload.
REQ-009 The block SHALL have port out_valid  out  1  as the downstream data-available indication.
REQ-010 The block SHALL have port out_ready  in  1  as the downstream accept.
REQ-011 The block SHALL have port out_data  out  SRAM_WIDTH  as the downstream payload.
REQ-012 The block SHALL have SRAM-side ports addr_w, addr_r  out  SRAM_DEPTH_BIT  as the SRAM write and read addresses.
REQ-013 The block SHALL have SRAM-side ports write_en, read_en  out  1  as the SRAM strobes.
REQ-014 The block SHALL have SRAM-side port sram_wdata  out  SRAM_WIDTH  as the data to the SRAM data_in.
REQ-015 The block SHALL have SRAM-side port sram_rdata  in  SRAM_WIDTH  as the data from the SRAM registered data_out.
REQ-016 The block SHALL have port level  out  SRAM_DEPTH_BIT+2  giving the total entries held.

Function
REQ-017 The block SHALL push when in_valid&in_ready: write_en=1, addr_w=wptr, sram_wdata=in_data in the same cycle, with wptr incrementing at the edge.
REQ-018 The block SHALL drive in_ready = (scount < SRAM_DEPTH) & !rst, where scount (SRAM_DEPTH_BIT+1 bits) counts entries written but not yet read.
REQ-019 The block SHALL assume the SRAM read latency is exactly one edge: read_en sampled at edge N means sram_rdata is valid after edge N until the next read.
REQ-020 The block SHALL hold an internal 2-entry in-order output buffer (obuf) and an in-flight flag infl that is set the cycle after read_en.
REQ-021 The block SHALL assert read_en = (scount>0) & (obuf_cnt + infl - pop < 2), where pop = out_valid&out_ready; addr_r=rptr, with rptr incrementing on read_en.
REQ-022 The block SHALL write sram_rdata into obuf at the edge ending each cycle in which infl=1; the entry is never dropped.
REQ-023 The block SHALL drive out_valid = (obuf_cnt>0) and out_data = oldest obuf entry; out_data SHALL hold stable while out_valid&!out_ready.
REQ-024 The block SHALL have latency such that a push at edge T into an otherwise empty block gives out_valid=1 after edge T+2, with out_data equal to the pushed word.
REQ-025 The block SHALL deliver one word per cycle sustained with in_valid and out_ready held high.
REQ-026 The block SHALL wrap wptr and rptr modulo SRAM_DEPTH with no special case.
REQ-027 When a push and a read occur in the same cycle, the block SHALL leave scount unchanged.
REQ-028 When a capture and a pop occur in the same cycle, the block SHALL leave obuf_cnt unchanged and SHALL preserve order.
REQ-029 The block SHALL compute level = scount + infl + obuf_cnt, with a maximum of SRAM_DEPTH+2.
REQ-030 The block SHALL ignore a push attempt while in_ready=0, with no write_en.
REQ-031 The block SHALL ignore out_ready while out_valid=0.
REQ-032 The block SHALL ensure a read never targets an address written in the same cycle, because scount counts only entries written at prior edges.

Reset
REQ-033 While rst=1, the block SHALL synchronously clear wptr, rptr, scount, infl and obuf_cnt.
REQ-034 While rst=1, the block SHALL drive in_ready=0, out_valid=0, write_en=0, read_en=0 and level=0.
REQ-035 The block SHALL drive out_data, addr_w, addr_r and sram_wdata to 0 while rst=1.
REQ-036 On reset mid-operation, the block SHALL discard all stored and in-flight data; the first push after reset SHALL use addr_w=0.
REQ-037 The block SHALL NOT clear SRAM contents on reset.

Verification (SRAM_DEPTH_BIT=2, SRAM_WIDTH=28, SRAM model with 1-edge read latency)
REQ-038 Verification SHALL check single word: push 0xABCDEF0 at edge T -> read_en in the next cycle with addr_r=0; out_valid=1 and out_data=0xABCDEF0 after edge T+2; level=1 throughout.
REQ-039 Verification SHALL check fill with out_ready=0: push values 1..7 back-to-back -> values 1..6 accepted and 7 stalled; level=6; in_ready=0 once scount=4; obuf holds 1,2.
REQ-040 Verification SHALL check drain: from the full state, set out_ready=1 -> outputs 1..6 in order on consecutive cycles, then out_valid=0 and level=0.
REQ-041 Verification SHALL check streaming with wrap: in_valid=out_ready=1 for 20 words 0..19 -> outputs 0..19 in order, one per cycle after the 2-edge latency; addr_w wraps 3->0 repeatedly.
REQ-042 Verification SHALL check backpressure: toggle out_ready every cycle during streaming -> no loss or duplication, and out_data stable while stalled.
REQ-043 Verification SHALL check reset mid-stream: assert rst for 1 cycle with infl=1 and level=5 -> level=0 and out_valid=0 the next cycle; the next push uses addr_w=0, and only that word appears at the output.
